lc3b_mem_port: RTL
==================

# lc3b_mem_port

Memory-side receiver for the datapath's shared 16-bit bus: captures bus values into MAR and MDR, runs variable-latency memory read/write transactions over a ready handshake, and presents the MDR value back to the bus driver. Byte reads are selected by MAR[0] and sign-extended. The port sits between the bus (loads and gated drive) and the external memory model, and is sequenced by control-store signals (ld_mar, ld_mdr, mem_req).

## Interface
- WAIT_MAX, 15: timeout threshold in ACCESS cycles (used only with MEM_TIMEOUT_EN); 1..255
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- bus_in  input  16  current shared-bus value
- ld_mar  input  1  load MAR from bus_in
- ld_mdr  input  1  load MDR from bus_in
- mem_req  input  1  start a transaction (single-cycle pulse or level; sampled only in IDLE)
- mem_wr  input  1  1 = write, 0 = read; sampled with mem_req
- mem_word  input  1  1 = word, 0 = byte; sampled with mem_req
- mdr_out  output  16  value offered to the bus gate: MDR, or sext8 of selected byte after a byte read
- busy  output  1  high in ACCESS
- done  output  1  one-cycle pulse, transaction completed
- mem_err  output  1  one-cycle pulse, misaligned word access or timeout
- mem_en  output  1  memory request, held high through ACCESS
- mem_we  output  1  memory write strobe, valid while mem_en
- mem_be  output  2  byte enables, valid while mem_en
- mem_addr  output  16  {MAR[15:1], 1'b0}
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data, valid when mem_ready
- mem_ready  input  1  memory completes the current access

## Operation
- States: IDLE, ACCESS. Reset: IDLE; MAR=0, MDR=0, op registers 0; all outputs 0 (mdr_out=0).
- IDLE: ld_mar/ld_mdr load on the edge. If mem_req: latch mem_wr/mem_word. If mem_word=1 and the MAR value after this edge has bit 0 set: stay IDLE, pulse mem_err next cycle, no mem_en. Otherwise go to ACCESS.
- ACCESS: mem_en=1, mem_we=op_wr. Word: mem_be=2'b11, mem_wdata=MDR. Byte: mem_be = MAR[0] ? 2'b10 : 2'b01, mem_wdata={MDR[7:0],MDR[7:0]}. On mem_ready: read loads MDR<=mem_rdata (full word); go IDLE, done=1 for the following cycle.
- mdr_out: last completed op was a byte read -> {{8{b[7]}},b}, where b = MAR[0] ? MDR[15:8] : MDR[7:0]; otherwise MDR. Any ld_mdr clears byte-read mode.
- During ACCESS, ld_mar, ld_mdr and mem_req are ignored; MAR/MDR are frozen.
- Simultaneous load and request in IDLE: loads apply first, so the transaction uses the newly loaded MAR/MDR.

## Timing
- mem_req sampled at edge k -> mem_en high from cycle k+1.
- mem_ready sampled at edge k+n (n>=1) -> MDR updated, mem_en low, and done high during cycle k+n+1. Minimum request-to-done is 2 cycles; back-to-back mem_req is accepted in the done cycle.
- Misaligned word: mem_err high in cycle k+1; mem_en stays 0.
- Async rst mid-ACCESS: immediate return to IDLE, mem_en drops without an edge, no done pulse, MDR cleared.
- mem_ready while IDLE is ignored.

## Configuration
- MEM_TIMEOUT_EN defined: an 8-bit counter clears on ACCESS entry and increments each ACCESS cycle without mem_ready. When it reaches WAIT_MAX, the port returns to IDLE, pulses mem_err (not done) in the next cycle, and leaves MDR unchanged. mem_ready in the same cycle as the timeout wins, giving normal completion.
- Not defined: no counter; ACCESS waits indefinitely for mem_ready; mem_err is used only for misalignment.

## Test plan
- Word write: bus 0x3000 with ld_mar, bus 0xBEEF with ld_mdr, mem_req wr word, ready after 3 cycles -> mem_addr=0x3000, be=11, wdata=0xBEEF, one done pulse, busy for 3 cycles.
- Byte read, high byte: MAR=0x3001, memory returns 0x80FF -> MDR=0x80FF, mdr_out=0xFF80; with MAR=0x3000 -> mdr_out=0xFFFF; with MAR=0x3000 and memory returning 0x127F -> mdr_out=0x007F.
- Byte write: MAR=0x2005, MDR=0x1234 -> be=10, wdata=0x3434, mem_addr=0x2004.
- Misaligned word read: MAR=0x4001 -> mem_err pulse, mem_en never high, MDR unchanged.
- ld_mar 0x5555 and mem_req during ACCESS -> ignored, MAR unchanged, no second transaction. ld_mar and mem_req in the same IDLE cycle -> access uses the new address.
- Reset asserted mid-ACCESS -> mem_en=0 immediately, no done, MAR=MDR=0. With MEM_TIMEOUT_EN and WAIT_MAX=4, no ready -> mem_err 5 cycles after request, MDR unchanged.

Source files
------------

// File: rtl/lc3b_mem_port.sv
// lc3b_mem_port: captures bus values into MAR/MDR and runs ready-handshake memory accesses.
// Optional define MEM_TIMEOUT_EN aborts an ACCESS after WAIT_MAX cycles without mem_ready.
module lc3b_mem_port #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bus_in,
    input  logic        ld_mar,
    input  logic        ld_mdr,
    input  logic        mem_req,
    input  logic        mem_wr,
    input  logic        mem_word,
    output logic [15:0] mdr_out,
    output logic        busy,
    output logic        done,
    output logic        mem_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [1:0]  mem_be,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready
);
    if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
        $error("WAIT_MAX must be in 1..255");
    end

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [15:0] mar_q, mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic        op_wr_q, op_wr_d;
    logic        op_word_q, op_word_d;
    logic        byte_rd_q, byte_rd_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  byte_sel;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout;
    assign timeout = (cnt_q == 8'(WAIT_MAX - 1));
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mar_q     <= '0;
            mdr_q     <= '0;
            op_wr_q   <= 1'b0;
            op_word_q <= 1'b0;
            byte_rd_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            mar_q     <= mar_d;
            mdr_q     <= mdr_d;
            op_wr_q   <= op_wr_d;
            op_word_q <= op_word_d;
            byte_rd_q <= byte_rd_d;
            done_q    <= done_d;
            err_q     <= err_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        mar_d     = mar_q;
        mdr_d     = mdr_q;
        op_wr_d   = op_wr_q;
        op_word_d = op_word_q;
        byte_rd_d = byte_rd_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (ld_mar) mar_d = bus_in;
                if (ld_mdr) begin
                    mdr_d     = bus_in;
                    byte_rd_d = 1'b0;
                end
                // Alignment is judged on the MAR value this edge will hold.
                if (mem_req) begin
                    op_wr_d   = mem_wr;
                    op_word_d = mem_word;
                    if (mem_word && mar_d[0]) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ACCESS;
`ifdef MEM_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_ready) begin
                    if (!op_wr_q) mdr_d = mem_rdata;
                    byte_rd_d = !op_wr_q && !op_word_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy      = (state_q == ACCESS);
    assign mem_en    = busy;
    assign mem_we    = busy && op_wr_q;
    assign mem_be    = !busy ? 2'b00 : (op_word_q ? 2'b11 : (mar_q[0] ? 2'b10 : 2'b01));
    assign mem_addr  = {mar_q[15:1], 1'b0};
    assign mem_wdata = op_word_q ? mdr_q : {mdr_q[7:0], mdr_q[7:0]};
    assign done      = done_q;
    assign mem_err   = err_q;

    assign byte_sel  = mar_q[0] ? mdr_q[15:8] : mdr_q[7:0];
    assign mdr_out   = byte_rd_q ? {{8{byte_sel[7]}}, byte_sel} : mdr_q;

endmodule
